// File: rtl/instruction_loader_if.sv
// Host byte link plus sequencer read port for the instruction loader.
// The master modport is the host/sequencer side, the slave modport is the loader.
interface instruction_loader_if #(
    parameter int unsigned ADDR_SIZE = 16
);
    logic [7:0]           in_byte;
    logic                 in_valid;
    logic                 in_ready;
    logic                 seq_running;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [63:0]          flg;
    logic [3:0]           op_code;
    logic [19:0]          data;
    logic [31:0]          time_arg;
    logic                 loading;
    logic                 done;
    logic                 err;

    modport master (
        output in_byte, in_valid, seq_running, rd_addr,
        input  in_ready, flg, op_code, data, time_arg, loading, done, err
    );

    modport slave (
        input  in_byte, in_valid, seq_running, rd_addr,
        output in_ready, flg, op_code, data, time_arg, loading, done, err
    );
endinterface

// File: rtl/instruction_loader.sv
// Parses host write commands, assembles 15-byte instructions into 120-bit words
// and stores them in a read-first instruction RAM fetched by the sequencer.
module instruction_loader #(
    parameter int unsigned ADDR_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_loader_if.slave   bus
);
    localparam int unsigned WORD_W         = 120;
    localparam int unsigned DEPTH          = 1 << ADDR_SIZE;
    localparam int unsigned BYTES_PER_WORD = 15;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned ASM_W          = WORD_W - 8;
    localparam int unsigned CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_PAYLOAD
    } state_t;

    state_t               r_state;
    logic [7:0]           r_addr_hi;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [CNT_W-1:0]     r_remaining;
    logic [IDX_W-1:0]     r_byte_idx;
    logic [ASM_W-1:0]     r_asm;
    logic                 r_done;
    logic                 r_err;
    logic [WORD_W-1:0]    r_mem [DEPTH];
    logic [WORD_W-1:0]    r_rd_word;

    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_last_byte;
    logic                 w_wr_en;
    logic [WORD_W-1:0]    w_wr_word;
    logic [15:0]          w_start_addr;
    logic [CNT_W-1:0]     w_count;

    // Payload bytes stall while the sequencer runs; header bytes never do.
    assign w_ready      = !reset && !(r_state == S_PAYLOAD && bus.seq_running);
    assign w_xfer       = bus.in_valid && w_ready;
    assign w_last_byte  = (r_state == S_PAYLOAD) && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign w_wr_en      = w_xfer && w_last_byte;
    assign w_wr_word    = {r_asm, bus.in_byte};
    assign w_start_addr = {r_addr_hi, bus.in_byte};
    assign w_count      = {r_remaining[CNT_W-1:8], bus.in_byte};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr_hi   <= 8'h00;
            r_wr_addr   <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.in_byte == 8'h01) begin
                            r_state <= S_ADDR_HI;
                            r_err   <= 1'b0;
                        end else if (bus.in_byte != 8'h00) begin
                            r_err   <= 1'b1;
                        end
                    end
                    S_ADDR_HI: begin
                        r_addr_hi <= bus.in_byte;
                        r_state   <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        r_wr_addr <= ADDR_SIZE'(w_start_addr);
                        r_state   <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        r_remaining <= {bus.in_byte, 8'h00};
                        r_state     <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        r_remaining <= w_count;
                        r_byte_idx  <= '0;
                        if (w_count == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_last_byte) begin
                            r_byte_idx  <= '0;
                            r_wr_addr   <= r_wr_addr + ADDR_SIZE'(1);
                            r_remaining <= r_remaining - CNT_W'(1);
                            if (r_remaining == CNT_W'(1)) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_asm      <= {r_asm[ASM_W-9:0], bus.in_byte};
                            r_byte_idx <= r_byte_idx + IDX_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // RAM is deliberately left out of reset; contents survive a loader reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_wr_word;
        end
    end

    // Read-first: a same-cycle write to rd_addr is seen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_word <= '0;
        end else begin
            r_rd_word <= r_mem[bus.rd_addr];
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.flg      = r_rd_word[119:56];
    assign bus.op_code  = r_rd_word[55:52];
    assign bus.data     = r_rd_word[51:32];
    assign bus.time_arg = r_rd_word[31:0];
    assign bus.loading  = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader: command-level model of the host
// protocol with an associative-array image of the instruction RAM.
module tb_instruction_loader;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct packed {
        logic [63:0] flg;
        logic [3:0]  op;
        logic [19:0] data;
        logic [31:0] t;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    instr_t model_mem [int];
    instr_t wq [$];

    instruction_loader_if #(.ADDR_SIZE(AW)) bus ();

    instruction_loader #(.ADDR_SIZE(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.flg  = {$urandom, $urandom};
        r.op   = 4'($urandom);
        r.data = 20'($urandom);
        r.t    = $urandom;
        return r;
    endfunction

    function automatic logic [7:0] instr_byte(input instr_t w, input int k);
        logic [119:0] bits;
        bits = w;
        return bits[119-8*k -: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit got;
        int n;
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!got) check("xfer_timeout", 0, 1);
    endtask

    task automatic send_header(input logic [15:0] addr, input logic [15:0] n);
        bus.seq_running = 1'($urandom);
        send_byte(8'h01);
        check("loading_hdr", bus.loading, 1);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        bus.seq_running = 1'b0;
    endtask

    task automatic read_check(input int addr);
        instr_t e;
        bus.rd_addr = AW'(addr);
        @(posedge clk); #1;
        e = model_mem[addr];
        check($sformatf("flg@%0h", addr), bus.flg, e.flg);
        check($sformatf("op@%0h", addr), bus.op_code, e.op);
        check($sformatf("data@%0h", addr), bus.data, e.data);
        check($sformatf("time@%0h", addr), bus.time_arg, e.t);
    endtask

    // Sends a full write command for the words in wq; optional stall before
    // byte 8 of the first word and a same-address read on the final byte.
    task automatic write_cmd(input int addr, input bit stall, input bit collide);
        int     start;
        int     n;
        int     a;
        int     stall_bad;
        instr_t old_w;
        start = done_cnt;
        n = wq.size();
        send_header(16'(addr), 16'(n));
        for (int w = 0; w < n; w++) begin
            a = (addr + w) % DEPTH;
            for (int k = 0; k < 15; k++) begin
                if (stall && w == 0 && k == 8) begin
                    stall_bad = 0;
                    bus.seq_running = 1'b1;
                    bus.in_byte  = instr_byte(wq[w], k);
                    bus.in_valid = 1'b1;
                    repeat (10) begin
                        @(negedge clk);
                        if (bus.in_ready) stall_bad++;
                        @(posedge clk); #1;
                    end
                    check("stall_ready", 32'(stall_bad), 0);
                    bus.seq_running = 1'b0;
                end
                if (collide && w == n - 1 && k == 14) begin
                    bus.rd_addr = AW'(a);
                    old_w = model_mem[a];
                end
                send_byte(instr_byte(wq[w], k));
            end
            model_mem[a] = wq[w];
        end
        check("done_pulse", bus.done, 1);
        check("loading_end", bus.loading, 0);
        if (collide) begin
            check("collide_old", bus.flg, old_w.flg);
            check("collide_old_t", bus.time_arg, old_w.t);
        end
        @(posedge clk); #1;
        check("done_clear", bus.done, 0);
        check("done_count", 32'(done_cnt - start), 1);
        if (collide && n > 0) begin
            check("collide_new", bus.flg, wq[n-1].flg);
            check("collide_new_t", bus.time_arg, wq[n-1].t);
        end
        wq.delete();
    endtask

    initial begin
        instr_t w0;
        int     addrs [$];
        int     base;
        int     n;

        reset           = 1'b1;
        bus.in_byte     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.seq_running = 1'b0;
        bus.rd_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.in_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_loading", bus.loading, 0);
        check("rst_flg", bus.flg, 0);
        check("rst_time", bus.time_arg, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", bus.in_ready, 1);

        // Directed single-word write to address 5
        w0.flg = 64'h8000_0000_0000_0001; w0.op = 4'h7; w0.data = 20'hFFFFF; w0.t = 32'd10;
        wq.push_back(w0);
        write_cmd(5, 0, 0);
        bus.rd_addr = AW'(5);
        @(posedge clk); #1;
        check("dir_flg", bus.flg, 64'h8000_0000_0000_0001);
        check("dir_op", bus.op_code, 4'h7);
        check("dir_data", bus.data, 20'hFFFFF);
        check("dir_time", bus.time_arg, 32'd10);

        // Address wrap across the top of the RAM
        repeat (3) wq.push_back(rand_instr());
        write_cmd(DEPTH - 1, 0, 0);
        read_check(DEPTH - 1);
        read_check(0);
        read_check(1);

        // Zero-count command: done without any write
        write_cmd(5, 0, 0);
        read_check(5);

        // Unknown command byte, then no-op, then recovery
        send_byte(8'h5A);
        check("err_set", bus.err, 1);
        check("err_idle", bus.loading, 0);
        send_byte(8'h00);
        check("noop_idle", bus.loading, 0);
        check("noop_err_kept", bus.err, 1);
        send_byte(8'h01);
        check("err_clear", bus.err, 0);
        check("err_cmd_loading", bus.loading, 1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("err_cmd_done", bus.done, 1);
        @(posedge clk); #1;

        // Sequencer stall in the middle of an instruction
        repeat (2) wq.push_back(rand_instr());
        write_cmd(16'h0300, 1, 0);
        read_check(16'h0300);
        read_check(16'h0301);

        // Same-address read on the writing cycle
        wq.push_back(rand_instr());
        write_cmd(16'h0100, 0, 0);
        wq.push_back(rand_instr());
        write_cmd(16'h0100, 0, 1);

        // Reset mid-payload leaves the previous word intact
        wq.push_back(rand_instr());
        write_cmd(16'h0200, 0, 0);
        w0 = rand_instr();
        send_header(16'h0200, 16'd1);
        for (int k = 0; k < 7; k++) send_byte(instr_byte(w0, k));
        reset = 1'b1;
        #1;
        check("midrst_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        check("midrst_loading", bus.loading, 0);
        check("midrst_done", bus.done, 0);
        reset = 1'b0;
        read_check(16'h0200);

        // Random commands
        for (int c = 0; c < 20; c++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                wq.push_back(rand_instr());
                addrs.push_back((base + i) % DEPTH);
            end
            write_cmd(base, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) && model_mem.exists((base + n - 1) % DEPTH));
        end
        foreach (addrs[i]) read_check(addrs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
